// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl -- time-of-day register set with a mode/inc setting FSM.
//
// Ports
//   clk    in   rising-edge clock for all state
//   reset  in   synchronous, active-high reset (priority over all pulses)
//   tick   in   1 Hz enable pulse; advances time only in RUN
//   mode   in   pulse; advances the setting state
//   inc    in   pulse; increments the field selected by the setting state
//   hr     out  hours   0-23 (registered)
//   min    out  minutes 0-59 (registered)
//   sec    out  seconds 0-59 (registered)
//   state  out  RUN=0 SET_HR=1 SET_MIN=2 SET_SEC=3 SET_AL_HR=4 SET_AL_MIN=5
//   alarm  out  alarm-match flag (only with CLOCK_SET_CTRL_ALARM_EN)
//
// Build option: define CLOCK_SET_CTRL_ALARM_EN to add the alarm registers,
// the two alarm-setting states and the alarm port. Without it, SET_SEC
// returns straight to RUN.

module clock_set_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode,
  input  logic       inc,
  output logic [5:0] hr,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic [2:0] state
`ifdef CLOCK_SET_CTRL_ALARM_EN
  ,
  output logic       alarm
`endif
);

`ifdef CLOCK_SET_CTRL_ALARM_EN
  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HR     = 3'd1,
    SET_MIN    = 3'd2,
    SET_SEC    = 3'd3,
    SET_AL_HR  = 3'd4,
    SET_AL_MIN = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3
  } state_t;
`endif

  state_t cur;

  // state output is the FSM register itself
  assign state = cur;

  // Modular increment helpers
  function automatic logic [5:0] hr_inc(input logic [5:0] v);
    return (v == 6'd23) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [6:0] m60_inc(input logic [6:0] v);
    return (v == 7'd59) ? '0 : v + 7'd1;
  endfunction

`ifdef CLOCK_SET_CTRL_ALARM_EN
  logic [5:0] al_hr;
  logic [6:0] al_min;
  logic       al_match;

  // Match is evaluated on the current registered time, so alarm rises
  // one cycle after the matching time is displayed.
  assign al_match = (cur == RUN) && (hr == al_hr) && (min == al_min) &&
                    (sec == 7'd0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= RUN;
      hr     <= '0;
      min    <= '0;
      sec    <= '0;
`ifdef CLOCK_SET_CTRL_ALARM_EN
      al_hr  <= '0;
      al_min <= '0;
      alarm  <= 1'b0;
`endif
    end else begin
      case (cur)
        RUN: begin
          // full carry chain: 23:59:59 -> 00:00:00 in a single tick
          if (tick) begin
            if (sec == 7'd59) begin
              sec <= '0;
              if (min == 7'd59) begin
                min <= '0;
                hr  <= hr_inc(hr);
              end else begin
                min <= min + 7'd1;
              end
            end else begin
              sec <= sec + 7'd1;
            end
          end
          // mode together with tick: both take effect
          if (mode) cur <= SET_HR;
        end
        SET_HR: begin
          if (mode)     cur <= SET_MIN;
          else if (inc) hr  <= hr_inc(hr);
        end
        SET_MIN: begin
          if (mode)     cur <= SET_SEC;
          else if (inc) min <= m60_inc(min);
        end
        SET_SEC: begin
`ifdef CLOCK_SET_CTRL_ALARM_EN
          if (mode)     cur <= SET_AL_HR;
`else
          if (mode)     cur <= RUN;
`endif
          else if (inc) sec <= '0;
        end
`ifdef CLOCK_SET_CTRL_ALARM_EN
        SET_AL_HR: begin
          if (mode)     cur   <= SET_AL_MIN;
          else if (inc) al_hr <= hr_inc(al_hr);
        end
        SET_AL_MIN: begin
          if (mode)     cur    <= RUN;
          else if (inc) al_min <= m60_inc(al_min);
        end
`endif
        default: cur <= RUN;
      endcase

`ifdef CLOCK_SET_CTRL_ALARM_EN
      // user pulse dismisses; otherwise latch on match, drop once the
      // minute moves past the alarm minute
      if (mode || inc)           alarm <= 1'b0;
      else if (al_match)         alarm <= 1'b1;
      else if (min != al_min)    alarm <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, mode = 1'b0, inc = 1'b0;
  logic [5:0] hr;
  logic [6:0] min, sec;
  logic [2:0] state;
`ifdef CLOCK_SET_CTRL_ALARM_EN
  logic       alarm;
  localparam bit HAS_AL = 1'b1;
`else
  localparam bit HAS_AL = 1'b0;
`endif

  clock_set_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .mode  (mode),
    .inc   (inc),
    .hr    (hr),
    .min   (min),
    .sec   (sec),
    .state (state)
`ifdef CLOCK_SET_CTRL_ALARM_EN
    ,
    .alarm (alarm)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: time kept as seconds-of-day, state as a mode index
  int t_s   = 0;
  int m_st  = 0;
  int al_h  = 0;
  int al_m  = 0;
  bit m_alm = 0;

  typedef struct {
    int h; int m; int s; int st; bit al;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic int next_mode(input int s);
    if (s == 3) return HAS_AL ? 4 : 0;
    if (s == 5) return 0;
    return s + 1;
  endfunction

  task automatic model(input bit r, input bit tk, input bit md, input bit ic);
    int h, mi, s;
    bit match;
    h  = t_s / 3600;
    mi = (t_s / 60) % 60;
    s  = t_s % 60;
    match = (m_st == 0) && (h == al_h) && (mi == al_m) && (s == 0);
    if (r) begin
      t_s = 0; m_st = 0; al_h = 0; al_m = 0; m_alm = 0;
      return;
    end
    if (md || ic)        m_alm = 0;
    else if (match)      m_alm = 1;
    else if (mi != al_m) m_alm = 0;
    if (m_st == 0) begin
      if (tk) t_s = (t_s + 1) % 86400;
      if (md) m_st = 1;
    end else if (md) begin
      m_st = next_mode(m_st);
    end else if (ic) begin
      case (m_st)
        1: h  = (h + 1) % 24;
        2: mi = (mi + 1) % 60;
        3: s  = 0;
        4: al_h = (al_h + 1) % 24;
        5: al_m = (al_m + 1) % 60;
        default: ;
      endcase
      t_s = h * 3600 + mi * 60 + s;
    end
  endtask

  task automatic step(input bit r, input bit tk, input bit md, input bit ic);
    exp_t e;
    @(negedge clk);
    reset = r; tick = tk; mode = md; inc = ic;
    model(r, tk, md, ic);
    e.h = t_s / 3600; e.m = (t_s / 60) % 60; e.s = t_s % 60;
    e.st = m_st; e.al = m_alm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask
  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask
  task automatic to_run();
    for (int i = 0; i < 8 && m_st != 0; i++) step(0, 0, 1, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge after stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hr", int'(hr), e.h);
        chk("min", int'(min), e.m);
        chk("sec", int'(sec), e.s);
        chk("state", int'(state), e.st);
`ifdef CLOCK_SET_CTRL_ALARM_EN
        chk("alarm", int'(alarm), int'(e.al));
`endif
      end
    end
  end

  initial begin
    // reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    idle(2);

    // setting sequence: hr wraps 24->0 then +1, min wraps 60->0 then +1
    step(0, 0, 1, 0);
    incs(25);
    step(0, 0, 1, 0);
    incs(61);
    step(0, 0, 1, 0);
    incs(1);
    to_run();
    idle(1);

    // full rollover 23:59:59 -> 00:00:00
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    incs(23);
    step(0, 0, 1, 0);
    incs(59);
    to_run();
    ticks(59);
    ticks(2);

    // freeze in SET_MIN
    step(1, 0, 0, 0);
    ticks(3);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    ticks(5);
    to_run();
    ticks(1);

    // mode+inc in SET_HR; mode+tick in RUN at sec=5
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    to_run();
    ticks(5);
    step(0, 1, 1, 0);
    to_run();

    // reset mid-setting at 12:34:56 in SET_SEC, with pulses competing
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    incs(12);
    step(0, 0, 1, 0);
    incs(34);
    to_run();
    ticks(56);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 1);
    idle(1);

    // alarm at 00:01
    if (HAS_AL) begin
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      incs(1);
      to_run();
      ticks(60);
      idle(3);
      step(0, 0, 1, 0);
      idle(2);
      to_run();
      ticks(61);
      idle(1);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
